// File: rtl/uart_rx_param_if.sv
// Serial receiver bus: line/tick inputs, held word with valid/ack and error flags.
// master = receiver side, slave = line driver plus word consumer.
interface uart_rx_param_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  baud_tick;
  logic                  rx_in;
  logic [DATA_WIDTH-1:0] rx_data;
  logic                  rx_valid;
  logic                  rx_ack;
  logic                  parity_err;
  logic                  frame_err;
  logic                  overrun_err;
  logic                  busy;

  modport master (
    input  baud_tick,
    input  rx_in,
    input  rx_ack,
    output rx_data,
    output rx_valid,
    output parity_err,
    output frame_err,
    output overrun_err,
    output busy
  );

  modport slave (
    output baud_tick,
    output rx_in,
    output rx_ack,
    input  rx_data,
    input  rx_valid,
    input  parity_err,
    input  frame_err,
    input  overrun_err,
    input  busy
  );
endinterface

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: oversampled 3-point majority bit decisions,
// held output word with valid/ack handshake and parity/frame/overrun flags.
module uart_rx_param #(
  parameter int DATA_WIDTH  = 8,
  parameter int PARITY_MODE = 1,
  parameter int STOP_BITS   = 1,
  parameter int OVERSAMPLE  = 16,
  parameter int SYNC_STAGES = 2
) (
  input logic            sys_clk,
  input logic            reset,
  uart_rx_param_if.master bus
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam int H  = OVERSAMPLE / 2;

  localparam logic [TW-1:0] T_S0  = TW'(H - 1);
  localparam logic [TW-1:0] T_S1  = TW'(H);
  localparam logic [TW-1:0] T_DEC = TW'(H + 1);
  localparam logic [TW-1:0] T_END = TW'(OVERSAMPLE - 1);
  localparam logic [3:0]    LAST_D = 4'(DATA_WIDTH - 1);
  localparam logic [3:0]    LAST_S = 4'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_e;

  state_e state_q, state_d;

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [TW-1:0]          tick_q, tick_d;
  logic [3:0]             bit_q, bit_d;
  logic [DATA_WIDTH-1:0]  shift_q, shift_d;
  logic [1:0]             smp_q, smp_d;
  logic                   par_q, par_d;
  logic                   fer_q, fer_d;
  logic                   done_q, done_d;

  logic [DATA_WIDTH-1:0]  data_q, data_d;
  logic                   valid_q, valid_d;
  logic                   perr_q, perr_d;
  logic                   ferr_q, ferr_d;
  logic                   ovr_q, ovr_d;

  logic rx_s;
  logic tick;
  logic dec;
  logic bend;
  logic maj;
  logic par_exp;

  assign sync_d  = {sync_q[SYNC_STAGES-2:0], bus.rx_in};
  assign rx_s    = sync_q[SYNC_STAGES-1];
  assign tick    = bus.baud_tick;
  assign dec     = tick && (tick_q == T_DEC);
  assign bend    = tick && (tick_q == T_END);
  assign maj     = (smp_q[0] & smp_q[1]) | (smp_q[0] & rx_s) | (smp_q[1] & rx_s);
  assign par_exp = (^shift_q) ^ (PARITY_MODE == 2);

  always_ff @(posedge sys_clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      sync_q  <= '1;
      tick_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      smp_q   <= '0;
      par_q   <= 1'b0;
      fer_q   <= 1'b0;
      done_q  <= 1'b0;
      data_q  <= '0;
      valid_q <= 1'b0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sync_q  <= sync_d;
      tick_q  <= tick_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      smp_q   <= smp_d;
      par_q   <= par_d;
      fer_q   <= fer_d;
      done_q  <= done_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      perr_q  <= perr_d;
      ferr_q  <= ferr_d;
      ovr_q   <= ovr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (tick && !rx_s) state_d = START;
      end
      START: begin
        if (dec && maj)  state_d = IDLE;
        else if (bend)   state_d = DATA;
      end
      DATA: begin
        if (bend && bit_q == LAST_D)
          state_d = (PARITY_MODE != 0) ? PARITY : STOP;
      end
      PARITY: begin
        if (bend) state_d = STOP;
      end
      STOP: begin
        // leave at the decision point so the next start edge is caught early
        if (dec && bit_q == LAST_S) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    tick_d   = tick_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    smp_d    = smp_q;
    par_d    = par_q;
    fer_d    = fer_q;
    done_d   = 1'b0;
    bus.busy = (state_q != IDLE);

    if (tick) begin
      if (state_q == IDLE) begin
        if (!rx_s) begin
          tick_d = '0;
          bit_d  = '0;
          fer_d  = 1'b0;
        end
      end else begin
        tick_d = bend ? '0 : tick_q + 1'b1;
        if (tick_q == T_S0) smp_d[0] = rx_s;
        if (tick_q == T_S1) smp_d[1] = rx_s;
        if (state_q == DATA) begin
          if (dec)  shift_d = {maj, shift_q[DATA_WIDTH-1:1]};
          if (bend) bit_d   = (bit_q == LAST_D) ? 4'd0 : bit_q + 4'd1;
        end
        if (state_q == PARITY && dec) par_d = maj;
        if (state_q == STOP) begin
          if (dec && !maj)            fer_d  = 1'b1;
          if (dec && bit_q == LAST_S) done_d = 1'b1;
          if (bend)                   bit_d  = bit_q + 4'd1;
        end
      end
    end
  end

  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    perr_d  = perr_q;
    ferr_d  = ferr_q;
    ovr_d   = ovr_q;
    if (done_q) begin
      if (!valid_q || bus.rx_ack) begin
        data_d  = shift_q;
        perr_d  = (PARITY_MODE != 0) && (par_q != par_exp);
        ferr_d  = fer_q;
        valid_d = 1'b1;
        if (bus.rx_ack) ovr_d = 1'b0;
      end else begin
        ovr_d = 1'b1;
      end
    end else if (bus.rx_ack && valid_q) begin
      valid_d = 1'b0;
      ovr_d   = 1'b0;
    end
  end

  assign bus.rx_data     = data_q;
  assign bus.rx_valid    = valid_q;
  assign bus.parity_err  = perr_q;
  assign bus.frame_err   = ferr_q;
  assign bus.overrun_err = ovr_q;

endmodule

// File: doc/uart_rx_param.md
Name: uart_rx_param

Overview:
Parametrised UART receiver, the next-generation serial input stage of the UART datapath. It supports a configurable data width, parity mode, stop-bit count and oversample ratio. Each bit is sampled by 3-point majority vote. Received words are held in an output register with a valid/ack handshake, and parity, framing and overrun errors are reported alongside the data. It sits between the shared baud-tick generator and the host-side register/FIFO logic.

Parameters:
DATA_WIDTH, 8, data bits per frame; legal 5..9; sent LSB first.
PARITY_MODE, 1, 0 = none, 1 = even, 2 = odd.
STOP_BITS, 1, number of stop bits checked; 1 or 2.
OVERSAMPLE, 16, baud_tick pulses per bit; even, 8..32.
SYNC_STAGES, 2, rx_in synchroniser depth; at least 2.

Ports:
sys_clk  input  1  system clock; all logic on its rising edge.
reset  input  1  asynchronous, active-low reset.
baud_tick  input  1  one-sys_clk-wide oversample enable, OVERSAMPLE pulses per bit.
rx_in  input  1  asynchronous serial line; idles high.
rx_data  output  DATA_WIDTH  received word.
rx_valid  output  1  high while rx_data holds an unacknowledged word.
rx_ack  input  1  consumer acknowledge; clears rx_valid.
parity_err  output  1  parity mismatch on the held word; always 0 when PARITY_MODE = 0.
frame_err  output  1  a stop-bit sample was not 1 for the held word.
overrun_err  output  1  sticky; a frame completed while rx_valid = 1.
busy  output  1  frame reception in progress.

Behaviour:
- Reset (async assert, sync deassert by design): all outputs 0; synchroniser flops to 1; FSM to IDLE. Reset mid-frame aborts the frame with no rx_valid.
- rx_in passes through SYNC_STAGES flops before use. All FSM, tick_cnt and sampling updates occur only on cycles where baud_tick = 1.
- tick_cnt runs 0..OVERSAMPLE-1 and wraps at each bit boundary.
- Samples are taken at tick_cnt = H-1, H and H+1, where H = OVERSAMPLE/2. The bit value is the majority of the 3 samples and is decided at H+1.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: on a tick with synced rx = 0, go to START, set tick_cnt = 0, busy = 1.
  - START: at the decision point, a majority of 1 is a false start: go to IDLE and set busy = 0. A majority of 0 continues; at tick_cnt = OVERSAMPLE-1 go to DATA.
  - DATA: shift in DATA_WIDTH bits, LSB first. At the last bit boundary go to PARITY, or to STOP if PARITY_MODE = 0.
  - PARITY: capture the bit; expected = XOR of the data bits, inverted for odd mode.
  - STOP: check STOP_BITS bits. At the decision point of the last stop bit go directly to IDLE; do not wait for the bit end, so the next start edge is caught early. busy = 0 on entering IDLE.
- Completion, registered; effective on the sys_clk edge after the last stop decision tick:
  - If rx_valid = 0, or rx_ack = 1 on the same cycle: load rx_data, parity_err and frame_err; set rx_valid = 1.
  - Else: discard the frame, keep rx_data and its flags, set overrun_err = 1.
- A frame is delivered even with parity or framing errors; the flags qualify it.
- rx_ack with rx_valid = 1 clears rx_valid and overrun_err on the next edge. rx_data, parity_err and frame_err keep their values until the next load.
- rx_ack with rx_valid = 0 has no effect.
- When DATA_WIDTH = 9, the rx_data MSB is the 9th bit received.
- An rx_in change without a baud_tick has no effect beyond the synchroniser.

Test Plan:
1. Defaults; send 0xA5, parity 0, stop 1 -> rx_valid = 1, rx_data = 0xA5, parity_err = 0, frame_err = 0, busy low after the stop decision; ack clears rx_valid.
2. Send 0x3C with parity bit 1 (even mode) -> rx_data = 0x3C, parity_err = 1. Repeat with PARITY_MODE = 2 -> parity_err = 0.
3. Send 0x81 with stop bit 0 -> frame_err = 1, rx_valid = 1. With STOP_BITS = 2, second stop bit 0 -> frame_err = 1.
4. rx_in low for 4 ticks, then high -> busy pulses then falls; rx_valid stays 0. Invert one of the 3 samples of data bit 3 of 0x00 -> rx_data = 0x00.
5. Send 0x11 then 0x22 with no ack -> rx_data = 0x11, overrun_err = 1. Then ack -> rx_valid = 0, overrun_err = 0. Ack asserted on the completion cycle of 0x22 instead -> rx_data = 0x22, overrun_err = 0.
6. DATA_WIDTH = 7, PARITY_MODE = 0, OVERSAMPLE = 8; send 0x55 -> rx_data = 0x55. Assert reset mid-DATA -> all outputs 0, no rx_valid; the next frame 0x2A is received correctly.
